// File: rtl/img_pkg.sv
// Shared definitions for the pixel window controller: default geometry,
// line-buffer count, read FSM states and the 3x3 window type.
package img_pkg;

   localparam int IMG_WIDTH_DEF = 512;
   localparam int PIX_W_DEF     = 8;
   localparam int NUM_LINE_BUFS = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } rd_state_e;

   typedef logic [9*PIX_W_DEF-1:0] window_t;

   // Line-buffer index arithmetic wraps naturally over the four buffers.
   function automatic logic [1:0] buf_add(input logic [1:0] base, input logic [1:0] ofs);
      return base + ofs;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: single write port, registered 3-pixel read
// port starting at a base column. Columns past the line end read as zero.
module line_buffer
   import img_pkg::*;
#(
   parameter int  IMG_WIDTH = IMG_WIDTH_DEF,
   parameter int  PIX_W     = PIX_W_DEF,
   localparam int AW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
   input  logic               axi_clk,
   input  logic               axi_reset_n,
   input  logic               i_wr_en,
   input  logic [AW-1:0]      i_wr_col,
   input  logic [PIX_W-1:0]   i_wr_data,
   input  logic               i_rd_en,
   input  logic [AW-1:0]      i_rd_col,
   output logic [3*PIX_W-1:0] o_rd_data
);

   logic [PIX_W-1:0]   mem_q [IMG_WIDTH];
   logic [AW+1:0]      rd_idx_s [3];
   logic [3*PIX_W-1:0] rd_data_d;
   logic [3*PIX_W-1:0] rd_data_q;

   // Pixel storage; contents are deliberately left unreset.
   always_ff @(posedge axi_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_col] <= i_wr_data;
      end
   end

   // Column indices of the three window taps, widened to detect the line end.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         rd_idx_s[k] = {2'b00, i_rd_col} + (AW+2)'(k);
      end
   end

   // Next read data: fetch three taps on a read, zero-pad past the line end, else hold.
   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) begin
         for (int k = 0; k < 3; k++) begin
            if (rd_idx_s[k] < (AW+2)'(IMG_WIDTH)) begin
               rd_data_d[k*PIX_W +: PIX_W] = mem_q[rd_idx_s[k][AW-1:0]];
            end else begin
               rd_data_d[k*PIX_W +: PIX_W] = '0;
            end
         end
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Read data register.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/pixel_window_ctrl.sv
// 3x3 sliding-window generator over four round-robin line buffers.
// Optional build macro PIXWIN_OVF_DET_EN adds a sticky o_overflow flag
// reporting pixels dropped while all four buffers were full.
module pixel_window_ctrl
   import img_pkg::*;
#(
   parameter int IMG_WIDTH = IMG_WIDTH_DEF,
   parameter int PIX_W     = PIX_W_DEF
) (
   input  logic               axi_clk,
   input  logic               axi_reset_n,
   input  logic [PIX_W-1:0]   i_pixel_data,
   input  logic               i_pixel_data_valid,
   input  logic               i_ready,
   output logic [9*PIX_W-1:0] o_pixel_data,
   output logic               o_pixel_data_valid,
   output logic               o_intr
`ifdef PIXWIN_OVF_DET_EN
   ,
   output logic               o_overflow
`endif
);

   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int CW = $clog2(NUM_LINE_BUFS*IMG_WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_LINE_BUFS*IMG_WIDTH);
   localparam logic [CW-1:0] CNT_START = CW'(3*IMG_WIDTH);
   localparam logic [AW-1:0] COL_LAST  = AW'(IMG_WIDTH-1);

   logic [AW-1:0]      wcol_d, wcol_q, rcol_d, rcol_q;
   logic [1:0]         wbuf_d, wbuf_q, rbuf_d, rbuf_q, sel_d, sel_q;
   logic [CW-1:0]      cnt_d, cnt_q;
   rd_state_e          state_d, state_q;
   logic               valid_d, valid_q, intr_d, intr_q;
   logic               rd_step_s, wr_acc_s;
   logic [3*PIX_W-1:0] lb_rd_s [NUM_LINE_BUFS];
   logic [9*PIX_W-1:0] window_s;

   // A read step happens on every ready cycle in READ; a write is refused only when full with no read.
   always_comb begin
      rd_step_s = (state_q == ST_READ) && i_ready;
      wr_acc_s  = i_pixel_data_valid && ((cnt_q != CNT_FULL) || rd_step_s);
   end

   // Write column/buffer pointers advance round-robin on accepted writes.
   always_comb begin
      wcol_d = wcol_q;
      wbuf_d = wbuf_q;
      if (wr_acc_s) begin
         if (wcol_q == COL_LAST) begin
            wcol_d = '0;
            wbuf_d = buf_add(wbuf_q, 2'd1);
         end else begin
            wcol_d = wcol_q + AW'(1);
         end
      end else begin
         wcol_d = wcol_q;
      end
   end

   // Fill counter: a simultaneous write and read step cancel out.
   always_comb begin
      case ({wr_acc_s, rd_step_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Read FSM, read pointers and output strobes.
   always_comb begin
      state_d = state_q;
      rcol_d  = rcol_q;
      rbuf_d  = rbuf_q;
      sel_d   = sel_q;
      valid_d = 1'b0;
      intr_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q >= CNT_START) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rd_step_s) begin
               valid_d = 1'b1;
               sel_d   = rbuf_q;
               if (rcol_q == COL_LAST) begin
                  rcol_d  = '0;
                  rbuf_d  = buf_add(rbuf_q, 2'd1);
                  intr_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  rcol_d = rcol_q + AW'(1);
               end
            end else begin
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and status registers.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         wcol_q  <= '0;
         wbuf_q  <= '0;
         rcol_q  <= '0;
         rbuf_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         intr_q  <= 1'b0;
      end else begin
         wcol_q  <= wcol_d;
         wbuf_q  <= wbuf_d;
         rcol_q  <= rcol_d;
         rbuf_q  <= rbuf_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         valid_q <= valid_d;
         intr_q  <= intr_d;
      end
   end

   for (genvar g = 0; g < NUM_LINE_BUFS; g++) begin : g_lb
      line_buffer #(
         .IMG_WIDTH (IMG_WIDTH),
         .PIX_W     (PIX_W)
      ) u_lb (
         .axi_clk     (axi_clk),
         .axi_reset_n (axi_reset_n),
         .i_wr_en     (wr_acc_s && (wbuf_q == 2'(g))),
         .i_wr_col    (wcol_q),
         .i_wr_data   (i_pixel_data),
         .i_rd_en     (rd_step_s),
         .i_rd_col    (rcol_q),
         .o_rd_data   (lb_rd_s[g])
      );
   end

   // Window rows 0..2 come from the buffer read at the last step and its two successors.
   always_comb begin
      window_s = '0;
      for (int r = 0; r < 3; r++) begin
         window_s[3*PIX_W*r +: 3*PIX_W] = lb_rd_s[buf_add(sel_q, 2'(r))];
      end
   end

   assign o_pixel_data       = window_s;
   assign o_pixel_data_valid = valid_q;
   assign o_intr             = intr_q;

`ifdef PIXWIN_OVF_DET_EN
   logic ovf_d, ovf_q;

   // Sticky overflow: set by any refused write, cleared only by reset.
   always_comb begin
      ovf_d = ovf_q | (i_pixel_data_valid & ~wr_acc_s);
   end

   // Overflow flag register.
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Directed self-checking bench for pixel_window_ctrl (IMG_WIDTH 512, PIX_W 8).
module tb_pixel_window_ctrl;

   localparam int W = 512;

   logic        axi_clk = 1'b0;
   logic        axi_reset_n;
   logic [7:0]  i_pixel_data;
   logic        i_pixel_data_valid;
   logic        i_ready;
   logic [71:0] o_pixel_data;
   logic        o_pixel_data_valid;
   logic        o_intr;
`ifdef PIXWIN_OVF_DET_EN
   logic        o_overflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [71:0] win_q[$];
   int intr_idx[$];
   int intr_total = 0;

   always #5 axi_clk = ~axi_clk;

   pixel_window_ctrl #(.IMG_WIDTH(W), .PIX_W(8)) dut (
      .axi_clk            (axi_clk),
      .axi_reset_n        (axi_reset_n),
      .i_pixel_data       (i_pixel_data),
      .i_pixel_data_valid (i_pixel_data_valid),
      .i_ready            (i_ready),
      .o_pixel_data       (o_pixel_data),
      .o_pixel_data_valid (o_pixel_data_valid),
      .o_intr             (o_intr)
`ifdef PIXWIN_OVF_DET_EN
      ,
      .o_overflow         (o_overflow)
`endif
   );

   task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; sample 1 time unit after the edge and log windows / interrupts.
   task automatic cycle();
      @(posedge axi_clk);
      #1;
      if (o_pixel_data_valid) win_q.push_back(o_pixel_data);
      if (o_intr) begin
         intr_total++;
         intr_idx.push_back(win_q.size());
      end
   endtask

   task automatic push(input logic [7:0] v);
      i_pixel_data       = v;
      i_pixel_data_valid = 1'b1;
      cycle();
      i_pixel_data_valid = 1'b0;
   endtask

   task automatic clear_log();
      win_q.delete();
      intr_idx.delete();
      intr_total = 0;
   endtask

   task automatic do_reset();
      axi_reset_n        = 1'b0;
      i_pixel_data_valid = 1'b0;
      i_ready            = 1'b0;
      repeat (3) cycle();
      axi_reset_n = 1'b1;
      cycle();
      clear_log();
   endtask

   task automatic run_until(input int target, input int budget);
      int n;
      n = 0;
      while (win_q.size() < target && n < budget) begin
         cycle();
         n++;
      end
   endtask

   function automatic logic [71:0] win_at(input int i);
      if (i < win_q.size()) return win_q[i];
      return {72{1'b1}};
   endfunction

   function automatic int intr_at(input int i);
      if (i < intr_idx.size()) return intr_idx[i];
      return -1;
   endfunction

   // Every row holds (column + off) mod 256; columns past the line end are 0.
   function automatic logic [71:0] win_pat(input int col, input int off);
      logic [71:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            if (col + k < W) w[8*(3*r+k) +: 8] = 8'((col + k + off) % 256);
      return w;
   endfunction

   // Rows hold constants a (oldest), b, c; columns past the line end are 0.
   function automatic logic [71:0] win_rows(input int col, input int a, input int b, input int c);
      logic [71:0] w;
      int v[3];
      v[0] = a; v[1] = b; v[2] = c;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            if (col + k < W) w[8*(3*r+k) +: 8] = 8'(v[r]);
      return w;
   endfunction

   function automatic int errs_pat(input int first, input int off);
      int e;
      e = 0;
      for (int i = 0; i < W; i++) if (win_at(first + i) !== win_pat(i, off)) e++;
      return e;
   endfunction

   function automatic int errs_rows(input int first, input int a, input int b, input int c);
      int e;
      e = 0;
      for (int i = 0; i < W; i++) if (win_at(first + i) !== win_rows(i, a, b, c)) e++;
      return e;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int hold_errs;
      logic [71:0] prev;

      axi_reset_n        = 1'b0;
      i_pixel_data       = 8'd0;
      i_pixel_data_valid = 1'b0;
      i_ready            = 1'b0;

      // Reset state
      repeat (2) cycle();
      check_val("rst_data", o_pixel_data, 72'd0);
      check_val("rst_valid", {71'd0, o_pixel_data_valid}, 72'd0);
      check_val("rst_intr", {71'd0, o_intr}, 72'd0);
`ifdef PIXWIN_OVF_DET_EN
      check_val("rst_ovf", {71'd0, o_overflow}, 72'd0);
`endif
      axi_reset_n = 1'b1;
      cycle();
      clear_log();

      // Three lines of column pattern, then one full drain with i_ready high
      i_ready = 1'b1;
      for (int i = 0; i < 3*W; i++) push(8'((i % W) % 256));
      check_val("no_window_during_load", 72'(win_q.size()), 72'd0);
      lat = 0;
      while (win_q.size() == 0 && lat < 10) begin
         cycle();
         lat++;
      end
      check_val("first_valid_latency", 72'(lat), 72'd2);
      check_val("first_window", win_at(0), win_pat(0, 0));
      run_until(W, 600);
      repeat (10) cycle();
      check_val("line_window_count", 72'(win_q.size()), 72'(W));
      check_val("line_intr_count", 72'(intr_total), 72'd1);
      check_val("line_intr_pos", 72'(intr_at(0)), 72'(W));
      check_val("last_window_pad", win_at(W-1), win_pat(W-1, 0));
      check_val("line_stream_errs", 72'(errs_pat(0, 0)), 72'd0);

      // Fourth line loaded, then drained with i_ready toggling every cycle
      clear_log();
      i_ready = 1'b0;
      for (int i = 0; i < W; i++) push(8'(i % 256));
      hold_errs = 0;
      prev = o_pixel_data;
      for (int n = 0; n < 2*W + 16; n++) begin
         i_ready = (n % 2 == 0);
         cycle();
         if (!i_ready && (o_pixel_data_valid || o_pixel_data !== prev)) hold_errs++;
         prev = o_pixel_data;
      end
      i_ready = 1'b0;
      repeat (5) cycle();
      check_val("toggle_window_count", 72'(win_q.size()), 72'(W));
      check_val("toggle_stream_errs", 72'(errs_pat(0, 0)), 72'd0);
      check_val("toggle_intr_count", 72'(intr_total), 72'd1);
      check_val("toggle_hold_errs", 72'(hold_errs), 72'd0);

      // Constant lines 10/20/30/40, drain two lines
      do_reset();
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < W; i++) push(8'(10 * (l + 1)));
      i_ready = 1'b1;
      run_until(2*W, 1300);
      repeat (5) cycle();
      check_val("const_window_count", 72'(win_q.size()), 72'(2*W));
      check_val("const_line0_first", win_at(0), win_rows(0, 10, 20, 30));
      check_val("const_line1_first", win_at(W), win_rows(0, 20, 30, 40));
      check_val("const_line1_last", win_at(2*W-1), win_rows(W-1, 20, 30, 40));
      check_val("const_line0_errs", 72'(errs_rows(0, 10, 20, 30)), 72'd0);
      check_val("const_line1_errs", 72'(errs_rows(W, 20, 30, 40)), 72'd0);
      check_val("const_intr_count", 72'(intr_total), 72'd2);
      check_val("const_intr_pos", 72'(intr_at(1)), 72'(2*W));

      // Overflow: 2049 writes with no reads, the last one must be dropped
      do_reset();
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < W; i++) push(8'(l + 1));
`ifdef PIXWIN_OVF_DET_EN
      check_val("ovf_before_drop", {71'd0, o_overflow}, 72'd0);
`endif
      push(8'd99);
`ifdef PIXWIN_OVF_DET_EN
      check_val("ovf_after_drop", {71'd0, o_overflow}, 72'd1);
`endif
      i_ready = 1'b1;
      run_until(2*W, 1300);
      check_val("ovf_line0_first", win_at(0), win_rows(0, 1, 2, 3));
      check_val("ovf_line0_errs", 72'(errs_rows(0, 1, 2, 3)), 72'd0);
      check_val("ovf_line1_errs", 72'(errs_rows(W, 2, 3, 4)), 72'd0);
      repeat (5) cycle();
      for (int i = 0; i < W; i++) push(8'd5);
      lat = 0;
      while (win_q.size() <= 2*W && lat < 10) begin
         cycle();
         lat++;
      end
      check_val("ovf_refill_latency", 72'(lat), 72'd2);
      run_until(3*W, 700);
      check_val("ovf_refill_first", win_at(2*W), win_rows(0, 3, 4, 5));
      check_val("ovf_refill_errs", 72'(errs_rows(2*W, 3, 4, 5)), 72'd0);
`ifdef PIXWIN_OVF_DET_EN
      check_val("ovf_sticky", {71'd0, o_overflow}, 72'd1);
`endif

      // Asynchronous reset in the middle of a read line
      do_reset();
      i_ready = 1'b1;
      for (int i = 0; i < 3*W; i++) push(8'((i % W) % 256));
      run_until(101, 200);
      check_val("pre_reset_window", win_at(100), win_pat(100, 0));
      #2;
      axi_reset_n = 1'b0;
      #1;
      check_val("async_rst_data", o_pixel_data, 72'd0);
      check_val("async_rst_valid", {71'd0, o_pixel_data_valid}, 72'd0);
      check_val("async_rst_intr", {71'd0, o_intr}, 72'd0);
      repeat (2) cycle();
      axi_reset_n = 1'b1;
      cycle();
      for (int i = 0; i < 200; i++) push(8'hEE);
      axi_reset_n = 1'b0;
      cycle();
      axi_reset_n = 1'b1;
      cycle();
      clear_log();
      for (int i = 0; i < 3*W; i++) push(8'(((i % W) + 7) % 256));
      run_until(W, 700);
      repeat (5) cycle();
      check_val("reload_first", win_at(0), win_pat(0, 7));
      check_val("reload_errs", 72'(errs_pat(0, 7)), 72'd0);
      check_val("reload_intr_count", 72'(intr_total), 72'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_window_ctrl.md
PIXEL_WINDOW_CTRL -- requirements
Module: pixel_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512: pixels per image line.
REQ-002 SHALL have parameter PIX_W, default 8: bits per pixel.
REQ-003 SHALL have port axi_clk  in  1: the single clock; every flop is rising-edge.
REQ-004 SHALL have port axi_reset_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_data  in  PIX_W: incoming raster pixel.
REQ-006 SHALL have port i_pixel_data_valid  in  1: i_pixel_data is valid this cycle.
REQ-007 SHALL have port i_ready  in  1: downstream convolution stage accepts a window.
REQ-008 SHALL have port o_pixel_data  out  9*PIX_W: 3x3 window; slice [PIX_W*(3r+k) +: PIX_W] holds row r (0 = oldest line) and column offset k.
REQ-009 SHALL have port o_pixel_data_valid  out  1: o_pixel_data is valid.
REQ-010 SHALL have port o_intr  out  1: one-cycle pulse meaning a line buffer was freed and the upstream may send one more line.

Function
REQ-011 SHALL store pixels in 4 line buffers of IMG_WIDTH entries each, written round-robin: write column wcol runs 0..IMG_WIDTH-1 and write buffer wbuf runs 0..3; on wcol wrap, wbuf advances modulo 4.
REQ-012 SHALL keep fill counter cnt, range 0..4*IMG_WIDTH: +1 per accepted write; -1 per read step; unchanged when a write and a read happen in the same cycle.
REQ-013 SHALL drop a write when cnt == 4*IMG_WIDTH and the same cycle holds no read step; wcol, wbuf and cnt SHALL stay unchanged for the dropped write.
REQ-014 SHALL use a 2-state FSM. IDLE moves to READ in the cycle after cnt >= 3*IMG_WIDTH is seen. READ moves to IDLE after the read step with rcol == IMG_WIDTH-1.
REQ-015 In READ, a read step SHALL occur each cycle that i_ready == 1. rcol runs 0..IMG_WIDTH-1. Buffers rbuf, rbuf+1 and rbuf+2 (all modulo 4) are read at columns rcol, rcol+1 and rcol+2.
REQ-016 SHALL substitute 0 for any window column index >= IMG_WIDTH (right-edge zero padding).
REQ-017 SHALL register read data. o_pixel_data_valid SHALL be high exactly 1 cycle after each read step, and o_pixel_data SHALL hold that step's window.
REQ-018 SHALL, on the final read step of a line, advance rbuf modulo 4, reset rcol to 0, and pulse o_intr high for exactly 1 cycle, coincident with the last o_pixel_data_valid.
REQ-019 SHALL hold rcol, rbuf and the window output while i_ready == 0; o_pixel_data_valid SHALL be 0 in those cycles.
REQ-020 SHALL accept writes in any state, including into a buffer not currently being read.

Reset
REQ-021 SHALL, while axi_reset_n == 0, force the following to 0 / IDLE: wcol, wbuf, rcol, rbuf, cnt, FSM, o_pixel_data, o_pixel_data_valid and o_intr.
REQ-022 SHALL leave line-buffer RAM contents unreset. Reset asserted mid-line SHALL abandon that line, and the first line after reset SHALL start at wbuf 0.

Configuration
REQ-023 SHALL, when PIXWIN_OVF_DET_EN is defined, add output o_overflow (1 bit). o_overflow is a sticky flag set by any write dropped under REQ-013 and cleared only by reset.
REQ-024 SHALL, when PIXWIN_OVF_DET_EN is not defined, have no o_overflow port and no overflow logic; dropping still follows REQ-013.

Structure
REQ-025 SHALL place in shared package img_pkg: IMG_WIDTH/PIX_W defaults, the constant NUM_LINE_BUFS = 4, the FSM state enum, and the window type (9 x PIX_W).
REQ-026 SHALL instantiate sub-module line_buffer 4 times. line_buffer is an IMG_WIDTH x PIX_W single-write RAM with a 3-pixel registered read port from a base column.

Verification
REQ-027 Bench SHALL send 3*512 pixels with value = column mod 256 -> READ entered; first window row 0 = {0,1,2}; o_pixel_data_valid first rises 2 cycles after cnt reaches 1536.
REQ-028 Bench SHALL drain one full line with i_ready = 1 -> exactly 512 valid windows; o_intr high for exactly 1 cycle on window 512; last window columns 1 and 2 = 0.
REQ-029 Bench SHALL toggle i_ready 1/0 every cycle during READ -> 512 windows with no duplicates or gaps; o_intr still pulses once.
REQ-030 Bench SHALL write 2049 pixels with i_ready = 0 -> cnt holds at 2048; pixel 2049 dropped; with PIXWIN_OVF_DET_EN, o_overflow = 1 and stays 1.
REQ-031 Bench SHALL send lines 0..3 at constant values 10, 20, 30, 40 and drain two lines -> second line's windows have rows {20,30,40}.
REQ-032 Bench SHALL assert axi_reset_n = 0 at rcol 100 -> all outputs 0 asynchronously; a fresh 1536-pixel load restarts output from column 0.
